// File: rtl/led_pwm_pkg.sv
// ---------------------------------------------------------------------------
// led_pwm_pkg
// Shared constants for the LED PWM bank: register map offsets, CTRL and BLINK
// bit positions, and the default prescaler ratio.
// Optional feature macro used by the bank: LED_PWM_BLINK_EN.
// ---------------------------------------------------------------------------
package led_pwm_pkg;

    // Duty registers occupy addresses DUTY_BASE .. DUTY_BASE+CHANNELS-1.
    localparam int DUTY_BASE        = 0;

    // CTRL bit positions.
    localparam int CTRL_EN_BIT      = 0;

    // BLINK register: low bits are per-channel enables, bit 7 is the phase.
    localparam int BLINK_PHASE_BIT  = 7;
    localparam int BLINK_EN_MAX     = 7;

    localparam int DEFAULT_PRESCALE = 64;

    // CTRL sits directly after the last duty register.
    function automatic int ctrl_addr(input int channels);
        return DUTY_BASE + channels;
    endfunction

    // BLINK sits directly after CTRL.
    function automatic int blink_addr(input int channels);
        return DUTY_BASE + channels + 1;
    endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// ---------------------------------------------------------------------------
// led_pwm_timebase
// Timebase shared by every PWM channel: prescaler, PWM counter, frame
// boundary strobe and the registered frame_start pulse. With LED_PWM_BLINK_EN
// defined it also runs the blink frame counter and exports its phase.
//
// Ports:
//   dot_clk        in   clock, rising edge
//   rst            in   synchronous reset, active-high
//   pwm_cnt        out  PWM counter value
//   frame_boundary out  combinational: tick while pwm_cnt is all-ones
//   frame_start    out  registered frame_boundary (aligned with pwm_cnt == 0)
//   blink_phase    out  blink phase (only with LED_PWM_BLINK_EN)
// ---------------------------------------------------------------------------
module led_pwm_timebase
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic                dot_clk,
    input  logic                rst,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                frame_boundary,
    output logic                frame_start
`ifdef LED_PWM_BLINK_EN
    ,
    output logic                blink_phase
`endif
);

    // A one-bit prescaler is kept even for PRESCALE=1; it then sits at 0 and
    // tick is asserted every cycle.
    localparam int             PSW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

    logic [PSW-1:0] presc_cnt;
    logic           tick;

    assign tick           = (presc_cnt == PS_LAST);
    assign frame_boundary = tick && (pwm_cnt == '1);

    always_ff @(posedge dot_clk) begin
        if (rst) begin
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            frame_start <= 1'b0;
        end else begin
            presc_cnt   <= tick ? '0 : presc_cnt + PSW'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
            frame_start <= frame_boundary;
        end
    end

`ifdef LED_PWM_BLINK_EN
    // The phase is the counter MSB, so it toggles every 2^(12-PWM_BITS) frames.
    localparam int FCW = 13 - PWM_BITS;

    logic [FCW-1:0] frame_cnt;

    always_ff @(posedge dot_clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_boundary) begin
            frame_cnt <= frame_cnt + FCW'(1);
        end
    end

    assign blink_phase = frame_cnt[FCW-1];
`endif

endmodule

// File: rtl/led_pwm_bank.sv
// ---------------------------------------------------------------------------
// led_pwm_bank
// N-channel PWM LED driver with a small register file on the 8-bit CPU I/O
// bus. Duty writes land in a pending copy and move to the active copy only at
// a frame boundary, so outputs never glitch mid-frame. A write that coincides
// with the boundary goes straight into active as well.
// Optional feature macro: LED_PWM_BLINK_EN (adds the BLINK register and
// per-channel blanking on the blink phase).
//
// Ports:
//   dot_clk      in   clock, rising edge
//   rst          in   synchronous reset, active-high
//   wr_en        in   write strobe
//   wr_addr      in   write address
//   wr_data      in   write data
//   rd_addr      in   read address
//   rd_data      out  registered read data (1-cycle latency)
//   pwm_out      out  registered PWM outputs, active-high
//   frame_start  out  one-cycle pulse at each frame boundary
// ---------------------------------------------------------------------------
module led_pwm_bank
    import led_pwm_pkg::*;
#(
    parameter int CHANNELS  = 3,
    parameter int PWM_BITS  = 8,
    parameter int PRESCALE  = DEFAULT_PRESCALE,
    parameter int ADDR_BITS = 4
) (
    input  logic                 dot_clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [7:0]           wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [7:0]           rd_data,
    output logic [CHANNELS-1:0]  pwm_out,
    output logic                 frame_start
);

    localparam logic [ADDR_BITS-1:0] CTRL_ADDR = ADDR_BITS'(ctrl_addr(CHANNELS));

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                frame_boundary;
    logic                ctrl_en;
    logic                ctrl_en_d;
    logic                ctrl_wr;
    logic [PWM_BITS-1:0] duty_pend [CHANNELS];
    logic [CHANNELS-1:0] pwm_d;
    logic [7:0]          rd_d;

`ifdef LED_PWM_BLINK_EN
    localparam int BLINK_W = (CHANNELS < BLINK_EN_MAX) ? CHANNELS : BLINK_EN_MAX;
    localparam logic [ADDR_BITS-1:0] BLINK_ADDR = ADDR_BITS'(blink_addr(CHANNELS));

    logic               blink_phase;
    logic [BLINK_W-1:0] blink_en;
`endif

    led_pwm_timebase #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .dot_clk        (dot_clk),
        .rst            (rst),
        .pwm_cnt        (pwm_cnt),
        .frame_boundary (frame_boundary),
        .frame_start    (frame_start)
`ifdef LED_PWM_BLINK_EN
        ,
        .blink_phase    (blink_phase)
`endif
    );

    // The compare stage uses the enable value being written this cycle, so a
    // CTRL write reaches pwm_out on the same edge that updates CTRL.
    assign ctrl_wr   = wr_en && (wr_addr == CTRL_ADDR);
    assign ctrl_en_d = ctrl_wr ? wr_data[CTRL_EN_BIT] : ctrl_en;

    always_ff @(posedge dot_clk) begin
        if (rst) begin
            ctrl_en <= 1'b0;
        end else begin
            ctrl_en <= ctrl_en_d;
        end
    end

`ifdef LED_PWM_BLINK_EN
    // Channels beyond bit 6 have no blink enable; bit 7 is the phase.
    always_ff @(posedge dot_clk) begin
        if (rst) begin
            blink_en <= '0;
        end else if (wr_en && (wr_addr == BLINK_ADDR)) begin
            blink_en <= wr_data[BLINK_W-1:0];
        end
    end
`endif

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        localparam logic [ADDR_BITS-1:0] DUTY_ADDR = ADDR_BITS'(DUTY_BASE + ch);

        logic                duty_wr;
        logic                blanked;
        logic [PWM_BITS-1:0] pend;
        logic [PWM_BITS-1:0] act;

        assign duty_wr = wr_en && (wr_addr == DUTY_ADDR);

        always_ff @(posedge dot_clk) begin
            if (rst) begin
                pend <= '0;
                act  <= '0;
            end else begin
                if (duty_wr) begin
                    pend <= wr_data[PWM_BITS-1:0];
                end
                if (frame_boundary) begin
                    act <= duty_wr ? wr_data[PWM_BITS-1:0] : pend;
                end
            end
        end

`ifdef LED_PWM_BLINK_EN
        if (ch < BLINK_W) begin : g_blink
            assign blanked = blink_phase && blink_en[ch];
        end else begin : g_noblink
            assign blanked = 1'b0;
        end
`else
        assign blanked = 1'b0;
`endif

        assign duty_pend[ch] = pend;

        // All-ones duty is forced fully on instead of dropping out at the
        // counter's final step.
        assign pwm_d[ch] = ctrl_en_d && !blanked &&
                           ((act == '1) || (pwm_cnt < act));
    end

    always_ff @(posedge dot_clk) begin
        if (rst) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= pwm_d;
        end
    end

    // Read mux samples register values before this edge's writes, so a read
    // of the address being written returns the old contents.
    always_comb begin
        rd_d = 8'h00;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_addr == ADDR_BITS'(DUTY_BASE + i)) begin
                rd_d = 8'(duty_pend[i]);
            end
        end
        if (rd_addr == CTRL_ADDR) begin
            rd_d[CTRL_EN_BIT] = ctrl_en;
        end
`ifdef LED_PWM_BLINK_EN
        if (rd_addr == BLINK_ADDR) begin
            rd_d[BLINK_W-1:0]     = blink_en;
            rd_d[BLINK_PHASE_BIT] = blink_phase;
        end
`endif
    end

    always_ff @(posedge dot_clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= rd_d;
        end
    end

endmodule
